// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the dynamic branch predictor: counter states,
// default sizing and the saturating counter update.
package branch_predictor_pkg;

  localparam int unsigned BP_ENTRIES = 16;
  localparam int unsigned BP_XLEN    = 32;
  localparam int unsigned BP_CNT_W   = 32;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_cnt_t;

  // Move one step toward the resolved outcome, saturating at either end.
  function automatic bp_cnt_t bp_cnt_next(bp_cnt_t cur, logic taken);
    bp_cnt_t nxt;
    nxt = cur;
    if (taken) begin
      case (cur)
        STRONG_NT: nxt = WEAK_NT;
        WEAK_NT:   nxt = WEAK_T;
        WEAK_T:    nxt = STRONG_T;
        STRONG_T:  nxt = STRONG_T;
        default:   nxt = cur;
      endcase
    end else begin
      case (cur)
        STRONG_NT: nxt = STRONG_NT;
        WEAK_NT:   nxt = STRONG_NT;
        WEAK_T:    nxt = WEAK_NT;
        STRONG_T:  nxt = WEAK_T;
        default:   nxt = cur;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch-stage
// lookup, registered training from Execute, saturating mispredict statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BP_ENTRIES,
  parameter int unsigned IDX_W   = $clog2(ENTRIES),
  parameter int unsigned CNT_W   = BP_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [31:0]        PC_F,
  output logic               Predict_Taken_F,
  output logic [31:0]        Predict_Target_F,
  input  logic               Branch_E,
  input  logic [31:0]        PC_E,
  input  logic               Branch_Taken_E,
  input  logic [31:0]        Branch_Target_E,
  input  logic               Predict_Taken_E,
  output logic [CNT_W-1:0]   Mispredict_Count
);

  localparam int unsigned TAG_W = BP_XLEN - IDX_W - 2;

  // Flop-based table so reset can clear it and lookups stay asynchronous.
  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  bp_cnt_t           cnt_q    [ENTRIES];
  logic [CNT_W-1:0]  mispredict_q;

  logic [IDX_W-1:0]  idx_f;
  logic [TAG_W-1:0]  tag_f;
  logic              hit_f;
  logic [IDX_W-1:0]  idx_e;
  logic [TAG_W-1:0]  tag_e;
  logic              hit_e;
  logic              mispredict_c;
  logic              unused_pc_bits;

  assign idx_f = PC_F[IDX_W+1:2];
  assign tag_f = PC_F[31:IDX_W+2];
  assign idx_e = PC_E[IDX_W+1:2];
  assign tag_e = PC_E[31:IDX_W+2];

  // Instruction-alignment bits carry no index or tag information.
  assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

  // Fetch-stage lookup reads pre-update contents; no write bypass.
  always_comb begin
    hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    Predict_Taken_F  = hit_f && cnt_q[idx_f][1];
    Predict_Target_F = PC_F + 32'd4;
    if (Predict_Taken_F) begin
      Predict_Target_F = target_q[idx_f];
    end
  end

  always_comb begin
    hit_e        = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    mispredict_c = Branch_E && (Branch_Taken_E != Predict_Taken_E);
  end

  // Training and statistics; reset discards any same-cycle update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= WEAK_NT;
      end
      mispredict_q <= '0;
    end else begin
      if (Branch_E) begin
        if (hit_e) begin
          cnt_q[idx_e] <= bp_cnt_next(cnt_q[idx_e], Branch_Taken_E);
          if (Branch_Taken_E) begin
            target_q[idx_e] <= Branch_Target_E;
          end
        end else if (Branch_Taken_E) begin
          // Allocate on a taken miss, evicting whatever aliased here.
          valid_q[idx_e]  <= 1'b1;
          tag_q[idx_e]    <= tag_e;
          target_q[idx_e] <= Branch_Target_E;
          cnt_q[idx_e]    <= WEAK_T;
        end
      end
      if (mispredict_c && !(&mispredict_q)) begin
        mispredict_q <= mispredict_q + CNT_W'(1);
      end
    end
  end

  assign Mispredict_Count = mispredict_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed test of branch_predictor: cold reset, allocation, hysteresis,
// aliasing, same-cycle collision, reset-vs-update and counter saturation.
module tb_branch_predictor;

  logic        CLK;
  logic        RST;
  logic [31:0] PC_F;
  logic        Predict_Taken_F;
  logic [31:0] Predict_Target_F;
  logic        Branch_E;
  logic [31:0] PC_E;
  logic        Branch_Taken_E;
  logic [31:0] Branch_Target_E;
  logic        Predict_Taken_E;
  logic [3:0]  Mispredict_Count;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES (16),
    .CNT_W   (4)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .PC_F             (PC_F),
    .Predict_Taken_F  (Predict_Taken_F),
    .Predict_Target_F (Predict_Target_F),
    .Branch_E         (Branch_E),
    .PC_E             (PC_E),
    .Branch_Taken_E   (Branch_Taken_E),
    .Branch_Target_E  (Branch_Target_E),
    .Predict_Taken_E  (Predict_Taken_E),
    .Mispredict_Count (Mispredict_Count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One Execute-stage branch for a single cycle.
  task automatic train(input logic [31:0] pc, input logic taken,
                       input logic [31:0] tgt, input logic pred);
    Branch_E        = 1'b1;
    PC_E            = pc;
    Branch_Taken_E  = taken;
    Branch_Target_E = tgt;
    Predict_Taken_E = pred;
    @(posedge CLK);
    #1;
    Branch_E = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_t, input logic [31:0] exp_tgt);
    PC_F = pc;
    #1;
    check_eq({tag, "_taken"}, 32'(Predict_Taken_F), 32'(exp_t));
    check_eq({tag, "_target"}, Predict_Target_F, exp_tgt);
  endtask

  task automatic check_count(input string tag, input logic [3:0] exp);
    check_eq(tag, 32'(Mispredict_Count), 32'(exp));
  endtask

  initial begin
    RST = 1'b1; PC_F = 32'h0; Branch_E = 1'b0; PC_E = 32'h0;
    Branch_Taken_E = 1'b0; Branch_Target_E = 32'h0; Predict_Taken_E = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;

    // Cold table
    look("cold_100", 32'h100, 1'b0, 32'h104);
    check_count("cold_cnt", 4'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

    // Allocate on taken miss, predicted not-taken -> one mispredict
    train(32'h200, 1'b1, 32'h180, 1'b0);
    look("alloc_200", 32'h200, 1'b1, 32'h180);
    check_count("alloc_cnt", 4'd1);
    train(32'h200, 1'b1, 32'h180, 1'b1);
    train(32'h200, 1'b1, 32'h180, 1'b1);
    look("strong_200", 32'h200, 1'b1, 32'h180);
    check_count("strong_cnt", 4'd1);

    // Hysteresis: STRONG_T -> WEAK_T still taken, -> WEAK_NT not taken
    train(32'h200, 1'b0, 32'h180, 1'b1);
    look("hyst1_200", 32'h200, 1'b1, 32'h180);
    train(32'h200, 1'b0, 32'h180, 1'b1);
    look("hyst2_200", 32'h200, 1'b0, 32'h204);
    check_count("hyst_cnt", 4'd3);

    // Alias at index 0: 0x240 evicts 0x200; not-taken 0x280 miss is ignored
    train(32'h240, 1'b1, 32'h300, 1'b0);
    look("evict_200", 32'h200, 1'b0, 32'h204);
    look("alloc_240", 32'h240, 1'b1, 32'h300);
    train(32'h280, 1'b0, 32'h500, 1'b0);
    look("keep_240", 32'h240, 1'b1, 32'h300);
    look("miss_280", 32'h280, 1'b0, 32'h284);
    check_count("alias_cnt", 4'd4);

    // Bring 0x200 back and walk it to STRONG_NT
    train(32'h200, 1'b1, 32'h180, 1'b1);
    train(32'h200, 1'b0, 32'h180, 1'b0);
    train(32'h200, 1'b0, 32'h180, 1'b0);
    train(32'h200, 1'b0, 32'h180, 1'b0);
    look("snt_200", 32'h200, 1'b0, 32'h204);
    look("evict_240", 32'h240, 1'b0, 32'h244);

    // Same-cycle collision: STRONG_NT -> WEAK_NT, lookup sees old state
    PC_F = 32'h200;
    Branch_E = 1'b1; PC_E = 32'h200; Branch_Taken_E = 1'b1;
    Branch_Target_E = 32'h180; Predict_Taken_E = 1'b0;
    #1;
    look("coll1_pre", 32'h200, 1'b0, 32'h204);
    @(posedge CLK); #1;
    look("coll1_post", 32'h200, 1'b0, 32'h204);
    // Still asserted: WEAK_NT -> WEAK_T, pre-edge must not bypass
    look("coll2_pre", 32'h200, 1'b0, 32'h204);
    @(posedge CLK); #1;
    Branch_E = 1'b0;
    look("coll2_post", 32'h200, 1'b1, 32'h180);
    check_count("coll_cnt", 4'd6);

    // Reset in the same cycle as a taken update: table empty, update lost
    RST = 1'b1;
    Branch_E = 1'b1; PC_E = 32'h300; Branch_Taken_E = 1'b1;
    Branch_Target_E = 32'h500; Predict_Taken_E = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0; Branch_E = 1'b0;
    look("rst_200", 32'h200, 1'b0, 32'h204);
    look("rst_300", 32'h300, 1'b0, 32'h304);
    check_count("rst_cnt", 4'd0);

    // Disagreement on a bubble is not a mispredict
    Branch_E = 1'b0; Branch_Taken_E = 1'b1; Predict_Taken_E = 1'b0;
    @(posedge CLK); #1;
    check_count("bubble_cnt", 4'd0);

    // Saturation at 15 with CNT_W=4
    for (int i = 0; i < 14; i++) train(32'h600, 1'b0, 32'h700, 1'b1);
    check_count("sat14_cnt", 4'd14);
    for (int i = 0; i < 6; i++) train(32'h600, 1'b0, 32'h700, 1'b1);
    check_count("sat20_cnt", 4'd15);
    look("nt_miss_600", 32'h600, 1'b0, 32'h604);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
